// File: rtl/m_btb_assoc.sv
// m_btb_assoc: two-way set-associative branch target buffer with direction counters, per-set LRU and a flush walker
module m_btb_assoc #(
  parameter int SETS = 32,
  parameter int XLEN = 32,
  parameter int CB   = 2
) (
  input  logic            w_clock,
  input  logic            w_reset,
  input  logic [XLEN-1:0] w_pc,
  output logic            w_hit,
  output logic            w_taken,
  output logic [XLEN-1:0] w_dout,
  output logic            w_busy,
  input  logic            w_flush,
  input  logic            w_we,
  input  logic [XLEN-1:0] w_wpc,
  input  logic            w_wtaken,
  input  logic [XLEN-1:0] w_wd
);
  localparam int IW = $clog2(SETS);
  localparam int TW = XLEN - 2 - IW;
  localparam logic [0:0] FLUSH = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;
  localparam logic [CB-1:0] HALF = CB'(1) << (CB - 1);
  logic [0:0]      state;
  logic [IW-1:0]   cnt;
  logic [1:0]      valid [SETS];
  logic            lru   [SETS];
  logic [TW-1:0]   tags  [SETS][2];
  logic [XLEN-1:0] tgts  [SETS][2];
  logic [CB-1:0]   ctrs  [SETS][2];
  logic [IW-1:0]   ridx, widx;
  logic [TW-1:0]   rtag, wtag;
  logic            rh0, rh1, rway, uh0, uh1, uhit, victim, way, do_upd;
  logic [CB-1:0]   cur, nxt;
  logic            unused_ok;
  assign unused_ok = ^{w_pc[1:0], w_wpc[1:0]};
  assign w_busy = state == FLUSH;
  // Combinational lookup; way 0 wins on a double hit, everything masked while walking
  always_comb begin
    ridx    = w_pc[IW+1:2];
    rtag    = w_pc[XLEN-1:IW+2];
    rh0     = valid[ridx][0] && tags[ridx][0] == rtag;
    rh1     = valid[ridx][1] && tags[ridx][1] == rtag;
    rway    = !rh0;
    w_hit   = !w_busy && (rh0 || rh1);
    w_taken = w_hit && ctrs[ridx][rway][CB-1];
    w_dout  = w_hit ? tgts[ridx][rway] : '0;
  end
  // Update side: hit way or allocation victim, and the saturated counter value
  always_comb begin
    widx   = w_wpc[IW+1:2];
    wtag   = w_wpc[XLEN-1:IW+2];
    uh0    = valid[widx][0] && tags[widx][0] == wtag;
    uh1    = valid[widx][1] && tags[widx][1] == wtag;
    uhit   = uh0 || uh1;
    victim = !valid[widx][0] ? 1'b0 : !valid[widx][1] ? 1'b1 : lru[widx];
    way    = uhit ? !uh0 : victim;
    do_upd = state == RUN && !w_flush && w_we && (uhit || w_wtaken);
    cur    = ctrs[widx][way];
    nxt    = !uhit ? HALF : w_wtaken ? (&cur ? cur : cur + CB'(1)) : (|cur ? cur - CB'(1) : cur);
  end
  // Walker FSM: reset or flush request restarts the walk at set 0
  always_ff @(posedge w_clock or posedge w_reset) begin
    if (w_reset) begin
      state <= FLUSH;
      cnt   <= '0;
    end else if (w_flush) begin
      state <= FLUSH;
      cnt   <= '0;
    end else if (state == FLUSH) begin
      cnt <= cnt + IW'(1);
      if (cnt == IW'(SETS - 1)) state <= RUN;
    end
  end
  // Valid and LRU: cleared one set per cycle by the walker, set by updates
  always_ff @(posedge w_clock) begin
    if (state == FLUSH) begin
      valid[cnt] <= 2'b00;
      lru[cnt]   <= 1'b0;
    end else if (do_upd) begin
      valid[widx][way] <= 1'b1;
      lru[widx]        <= !way;
    end
  end
  // Payload arrays; target only moves on taken outcomes or allocation
  always_ff @(posedge w_clock) begin
    if (do_upd) begin
      tags[widx][way] <= wtag;
      ctrs[widx][way] <= nxt;
      if (w_wtaken) tgts[widx][way] <= w_wd;
    end
  end
endmodule

// File: tb/tb_m_btb_assoc.sv
// tb_m_btb_assoc: directed self-checking bench for the associative BTB
module tb_m_btb_assoc;
  logic        w_clock = 0, w_reset = 1, w_flush = 0, w_we = 0, w_wtaken = 0;
  logic [31:0] w_pc = 0, w_wpc = 0, w_wd = 0;
  logic        w_hit, w_taken, w_busy;
  logic [31:0] w_dout;
  int checks = 0, errs = 0;

  m_btb_assoc #(.SETS(32), .XLEN(32), .CB(2)) dut (
    .w_clock(w_clock), .w_reset(w_reset), .w_pc(w_pc), .w_hit(w_hit),
    .w_taken(w_taken), .w_dout(w_dout), .w_busy(w_busy), .w_flush(w_flush),
    .w_we(w_we), .w_wpc(w_wpc), .w_wtaken(w_wtaken), .w_wd(w_wd)
  );

  always #5 w_clock = ~w_clock;

  task automatic tick();
    @(posedge w_clock);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] d);
    w_we = 1; w_wpc = pc; w_wtaken = tk; w_wd = d;
    tick();
    w_we = 0;
  endtask

  task automatic look(input string nm, input logic [31:0] pc, input logic eh, input logic et, input logic [31:0] ed);
    w_pc = pc;
    #1;
    checks++;
    if (w_hit !== eh || w_taken !== et || w_dout !== ed) begin
      errs++;
      $display("FAIL %s pc=%h: got hit=%b taken=%b dout=%h, want hit=%b taken=%b dout=%h",
               nm, pc, w_hit, w_taken, w_dout, eh, et, ed);
    end
  endtask

  task automatic count_busy(input string nm, input int exp);
    int n = 0;
    while (w_busy === 1'b1 && n < 100) begin
      tick();
      n++;
      w_we = 0;
    end
    checks++;
    if (n != exp) begin
      errs++;
      $display("FAIL %s busy cycles: got %0d, want %0d", nm, n, exp);
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if (w_busy !== 1'b1) begin errs++; $display("FAIL reset_busy: got %b, want 1", w_busy); end
    look("reset_lookup", 32'h100, 0, 0, 0);
    w_reset = 0;
    count_busy("reset_walk", 32);
    look("post_reset_lookup", 32'h100, 0, 0, 0);
  endtask

  task automatic test_alloc();
    upd(32'h100, 1, 32'h2000);
    look("alloc_hit", 32'h100, 1, 1, 32'h2000);
    look("alloc_low_bits", 32'h102, 1, 1, 32'h2000);
    look("alloc_other_tag", 32'h180, 0, 0, 0);
  endtask

  task automatic test_counter();
    upd(32'h100, 0, 32'h9999);
    look("dec_1", 32'h100, 1, 0, 32'h2000);
    upd(32'h100, 0, 32'h9999);
    upd(32'h100, 0, 32'h9999);
    upd(32'h100, 0, 32'h9999);
    look("dec_sat", 32'h100, 1, 0, 32'h2000);
    upd(32'h100, 1, 32'h2000);
    look("inc_1", 32'h100, 1, 0, 32'h2000);
    upd(32'h100, 1, 32'h2000);
    look("inc_2", 32'h100, 1, 1, 32'h2000);
    upd(32'h100, 1, 32'h2000);
    upd(32'h100, 1, 32'h2000);
    look("inc_sat", 32'h100, 1, 1, 32'h2000);
    upd(32'h100, 0, 32'h2000);
    look("sat_then_dec", 32'h100, 1, 1, 32'h2000);
  endtask

  task automatic test_lru();
    upd(32'h1100, 1, 32'h4000);
    look("lru_way1_alloc", 32'h1100, 1, 1, 32'h4000);
    look("lru_way0_kept", 32'h100, 1, 1, 32'h2000);
    upd(32'h100, 1, 32'h2000);
    upd(32'h2100, 1, 32'h3000);
    look("lru_new", 32'h2100, 1, 1, 32'h3000);
    look("lru_recent", 32'h100, 1, 1, 32'h2000);
    look("lru_evicted", 32'h1100, 0, 0, 0);
  endtask

  task automatic test_nt_miss();
    upd(32'h300, 0, 32'h5000);
    look("nt_miss_noalloc", 32'h300, 0, 0, 0);
    upd(32'h1100, 1, 32'h6000);
    look("nt_lru_victim", 32'h100, 0, 0, 0);
    look("nt_lru_keep", 32'h2100, 1, 1, 32'h3000);
    look("nt_lru_new", 32'h1100, 1, 1, 32'h6000);
  endtask

  task automatic test_flush_conflict();
    w_flush = 1; w_we = 1; w_wpc = 32'h400; w_wtaken = 1; w_wd = 32'h7000;
    tick();
    w_flush = 0; w_we = 0;
    count_busy("flush_walk", 32);
    look("flush_drop", 32'h400, 0, 0, 0);
    look("flush_clear_a", 32'h2100, 0, 0, 0);
    look("flush_clear_b", 32'h1100, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    upd(32'h13C, 1, 32'h8000);
    look("b2b_alloc", 32'h13C, 1, 1, 32'h8000);
    w_reset = 1;
    tick();
    w_reset = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 5) look("walk_masked", 32'h13C, 0, 0, 0);
    end
    #2 w_reset = 1;
    #1;
    checks++;
    if (w_busy !== 1'b1) begin errs++; $display("FAIL midreset_busy: got %b, want 1", w_busy); end
    tick();
    w_reset = 0;
    w_we = 1; w_wpc = 32'h500; w_wtaken = 1; w_wd = 32'hA000;
    count_busy("midreset_walk", 32);
    look("busy_update_drop", 32'h500, 0, 0, 0);
    look("midreset_clear", 32'h13C, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_counter();
    test_lru();
    test_nt_miss();
    test_flush_conflict();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
endmodule
